fault_response_ctrl: RTL and testbench

Consumer at the far end of the fault detector's 2-bit status output (0 NORMAL, 1 WARNING, 2 FAULT, 3 SHUTDOWN). It turns that status into power-stage actions: gate enable, derate request and alarm. It runs a trip / cool-down / auto-retry sequence with a retry limit and a lockout that only the host can clear. Every status transition is logged, with a timestamp, into a small event FIFO that the host drains through a valid/ready handshake.

---
 rtl/fault_pkg.sv | 36 +++
 rtl/fault_event_fifo.sv | 78 +++++++
 rtl/fault_response_ctrl.sv | 137 +++++++++++++
 tb/tb_fault_response_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared definitions for the fault detector / fault response path:
// status codes, response FSM states and the event-log record layout.
package fault_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARNING  = 2'd1,
    ST_FAULT    = 2'd2,
    ST_SHUTDOWN = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    RS_RUN      = 3'd0,
    RS_DERATE   = 3'd1,
    RS_TRIP     = 3'd2,
    RS_COOLDOWN = 3'd3,
    RS_LOCKOUT  = 3'd4
  } resp_state_t;

  localparam int TS_W     = 8;
  localparam int TRIP_W   = 4;
  localparam int EVT_W    = 2 + 2 + TS_W;

  localparam logic [TRIP_W-1:0] TRIP_MAX = '1;

  typedef struct packed {
    status_t           prev;
    status_t           curr;
    logic [TS_W-1:0]   ts;
  } evt_rec_t;

  function automatic logic [TRIP_W-1:0] trip_inc_sat(input logic [TRIP_W-1:0] v);
    return (v == TRIP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fault_event_fifo.sv
// First-word-fall-through FIFO with a registered head/valid and a sticky
// overflow flag; a push while full is dropped unless a pop frees a slot.
module fault_event_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic              overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_n;
  logic [AW:0]       count;
  logic [AW:0]       count_n;
  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;
  logic              drop;
  logic [DATA_W-1:0] head_n;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  // Popping an empty FIFO is ignored, so an empty push+pop never bypasses.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign drop     = push && full && !pop_ok;
  assign rd_ptr_n = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
  assign count_n  = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

  // The next head is the word being written when it lands in the head slot.
  always_comb begin
    head_n = mem[rd_ptr_n];
    if (push_ok && (wr_ptr == rd_ptr_n)) begin
      head_n = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      head   <= head_n;
      valid  <= (count_n != '0);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fault_response_ctrl.sv
// Turns detector status into gate/derate/alarm actions with a trip,
// cool-down and retry-limited lockout sequence, and logs status changes.
module fault_response_ctrl
  import fault_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 16,
  parameter int RETRY_LIMIT     = 3,
  parameter int LOG_DEPTH       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        status_in,
  input  logic              clear_req,
  output logic              gate_en,
  output logic              derate,
  output logic              alarm,
  output logic [TRIP_W-1:0] trip_cnt,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [EVT_W-1:0]  evt_data,
  output logic              evt_overflow
);

  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TRIP_W-1:0] RETRY_LIM = TRIP_W'(RETRY_LIMIT);

  status_t           status;
  status_t           status_q;
  resp_state_t       state_q;
  resp_state_t       state_n;
  logic [CD_W-1:0]   cd_cnt;
  logic [TS_W-1:0]   ts;
  logic              trip_entry;
  logic              evt_push;
  evt_rec_t          evt_rec;

  assign status = status_t'(status_in);

  always_comb begin
    state_n = state_q;
    case (state_q)
      RS_RUN: begin
        case (status)
          ST_WARNING:  state_n = RS_DERATE;
          ST_FAULT:    state_n = RS_TRIP;
          ST_SHUTDOWN: state_n = RS_LOCKOUT;
          default:     state_n = RS_RUN;
        endcase
      end
      RS_DERATE: begin
        case (status)
          ST_NORMAL:   state_n = RS_RUN;
          ST_FAULT:    state_n = RS_TRIP;
          ST_SHUTDOWN: state_n = RS_LOCKOUT;
          default:     state_n = RS_DERATE;
        endcase
      end
      RS_TRIP: begin
        if (status == ST_SHUTDOWN) begin
          state_n = RS_LOCKOUT;
        end else if (status == ST_NORMAL) begin
          state_n = (trip_cnt >= RETRY_LIM) ? RS_LOCKOUT : RS_COOLDOWN;
        end
      end
      RS_COOLDOWN: begin
        case (status)
          ST_SHUTDOWN: state_n = RS_LOCKOUT;
          ST_WARNING,
          ST_FAULT:    state_n = RS_TRIP;
          default:     state_n = (cd_cnt == '0) ? RS_RUN : RS_COOLDOWN;
        endcase
      end
      RS_LOCKOUT: begin
        if (clear_req && (status == ST_NORMAL)) begin
          state_n = RS_RUN;
        end
      end
      default: state_n = RS_RUN;
    endcase
  end

  // A re-trip from COOLDOWN counts the same as a fresh trip from RUN/DERATE.
  assign trip_entry = (state_n == RS_TRIP) && (state_q != RS_TRIP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RS_RUN;
      gate_en  <= 1'b0;
      derate   <= 1'b0;
      alarm    <= 1'b0;
      trip_cnt <= '0;
      cd_cnt   <= '0;
      ts       <= '0;
      status_q <= ST_NORMAL;
    end else begin
      state_q  <= state_n;
      gate_en  <= (state_n == RS_RUN) || (state_n == RS_DERATE);
      derate   <= (state_n == RS_DERATE);
      alarm    <= (state_n == RS_LOCKOUT);
      ts       <= ts + 1'b1;
      status_q <= status;

      if (trip_entry) begin
        trip_cnt <= trip_inc_sat(trip_cnt);
      end else if ((state_q == RS_LOCKOUT) && (state_n == RS_RUN)) begin
        trip_cnt <= '0;
      end

      if ((state_q == RS_TRIP) && (state_n == RS_COOLDOWN)) begin
        cd_cnt <= CD_LOAD;
      end else if ((state_q == RS_COOLDOWN) && (state_n == RS_COOLDOWN)) begin
        cd_cnt <= cd_cnt - 1'b1;
      end
    end
  end

  assign evt_push     = (status != status_q);
  assign evt_rec.prev = status_q;
  assign evt_rec.curr = status;
  assign evt_rec.ts   = ts;

  fault_event_fifo #(
    .DATA_W (EVT_W),
    .DEPTH  (LOG_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (evt_push),
    .push_data (evt_rec),
    .pop       (evt_ready),
    .head      (evt_data),
    .valid     (evt_valid),
    .overflow  (evt_overflow)
  );

endmodule

// File: tb/tb_fault_response_ctrl.sv
// Bench for fault_response_ctrl: directed scenarios plus randomized status,
// clear and ready traffic, all compared against a queue-based reference model.
module tb_fault_response_ctrl;

  localparam int CD = 16;
  localparam int RL = 3;
  localparam int LD = 4;

  localparam int M_RUN  = 0;
  localparam int M_DER  = 1;
  localparam int M_TRIP = 2;
  localparam int M_COOL = 3;
  localparam int M_LOCK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  status_in;
  logic        clear_req;
  logic        gate_en;
  logic        derate;
  logic        alarm;
  logic [3:0]  trip_cnt;
  logic        evt_valid;
  logic        evt_ready;
  logic [11:0] evt_data;
  logic        evt_overflow;

  int checks = 0;
  int errors = 0;

  int          m_mode;
  int          m_trips;
  int          m_cd;
  int          m_ts;
  int          m_sq;
  logic [11:0] m_q[$];
  bit          m_ovf;
  bit          e_gate;
  bit          e_derate;
  bit          e_alarm;

  always #5 clk = ~clk;

  fault_response_ctrl #(
    .COOLDOWN_CYCLES (CD),
    .RETRY_LIMIT     (RL),
    .LOG_DEPTH       (LD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .status_in    (status_in),
    .clear_req    (clear_req),
    .gate_en      (gate_en),
    .derate       (derate),
    .alarm        (alarm),
    .trip_cnt     (trip_cnt),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_overflow (evt_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_trips = 0; m_cd = 0; m_ts = 0; m_sq = 0;
    m_q.delete(); m_ovf = 0;
    e_gate = 0; e_derate = 0; e_alarm = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  task automatic model_edge(input int s, input bit clr, input bit rdy);
    bit          pop;
    int          nm;
    logic [11:0] rec;
    pop = (m_q.size() > 0) && rdy;
    rec = {2'(m_sq), 2'(s), 8'(m_ts)};
    if (pop) void'(m_q.pop_front());
    if (s != m_sq) begin
      if (m_q.size() < LD) m_q.push_back(rec);
      else m_ovf = 1;
    end
    nm = m_mode;
    case (m_mode)
      M_RUN:  if (s == 1) nm = M_DER; else if (s == 2) nm = M_TRIP; else if (s == 3) nm = M_LOCK;
      M_DER:  if (s == 0) nm = M_RUN; else if (s == 2) nm = M_TRIP; else if (s == 3) nm = M_LOCK;
      M_TRIP: begin
        if (s == 3) nm = M_LOCK;
        else if (s == 0) begin
          if (m_trips >= RL) nm = M_LOCK;
          else begin nm = M_COOL; m_cd = CD - 1; end
        end
      end
      M_COOL: begin
        if (s == 3) nm = M_LOCK;
        else if (s != 0) nm = M_TRIP;
        else if (m_cd == 0) nm = M_RUN;
        else m_cd = m_cd - 1;
      end
      default: if (clr && s == 0) begin nm = M_RUN; m_trips = 0; end
    endcase
    if (nm == M_TRIP && m_mode != M_TRIP && m_trips < 15) m_trips++;
    m_mode   = nm;
    m_sq     = s;
    m_ts     = (m_ts + 1) % 256;
    e_gate   = (nm == M_RUN) || (nm == M_DER);
    e_derate = (nm == M_DER);
    e_alarm  = (nm == M_LOCK);
  endtask

  task automatic compare_all();
    check("gate_en", gate_en, e_gate);
    check("derate", derate, e_derate);
    check("alarm", alarm, e_alarm);
    check("trip_cnt", trip_cnt, m_trips);
    check("evt_valid", evt_valid, m_q.size() > 0);
    check("evt_overflow", evt_overflow, m_ovf);
    if (m_q.size() > 0) check("evt_data", evt_data, m_q[0]);
  endtask

  task automatic step(input int s, input bit clr, input bit rdy);
    @(negedge clk);
    status_in = 2'(s);
    clear_req = clr;
    evt_ready = rdy;
    @(posedge clk);
    model_edge(s, clr, rdy);
    #1;
    compare_all();
  endtask

  task automatic wait_reenable(output int n);
    n = 0;
    do begin
      step(0, 0, 1);
      n++;
    end while (gate_en !== 1'b1 && n < 100);
  endtask

  initial begin
    int n;
    int s;
    reset = 1'b1; status_in = 2'd0; clear_req = 1'b0; evt_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gate_en", gate_en, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_data", evt_data, 0);
    check("rst_trip_cnt", trip_cnt, 0);
    reset = 1'b0;

    step(0, 0, 1);
    check("gate_after_reset", gate_en, 1);

    // WARNING for 5 cycles then NORMAL, with the log held undrained.
    repeat (5) step(1, 0, 0);
    check("derate_warning", derate, 1);
    step(0, 0, 0);
    check("warn_evt_head", evt_data[11:8], 4'b0001);
    repeat (3) step(0, 0, 1);

    // Single trip and timed re-enable.
    repeat (3) step(2, 0, 1);
    check("trip_gate_off", gate_en, 0);
    wait_reenable(n);
    check("reenable_edges", n, CD + 1);
    check("trip_cnt_one", trip_cnt, 1);

    // Second and third trips reach lockout; clear only honoured with NORMAL.
    repeat (2) step(2, 0, 1);
    wait_reenable(n);
    repeat (2) step(2, 0, 1);
    step(0, 0, 1);
    check("lockout_alarm", alarm, 1);
    repeat (2) step(2, 1, 1);
    check("clear_ignored", alarm, 1);
    step(0, 1, 1);
    check("clear_trip_cnt", trip_cnt, 0);
    check("clear_gate_en", gate_en, 1);

    // FAULT mid-cooldown with the counter at 7 re-trips and reloads.
    repeat (2) step(2, 0, 1);
    step(0, 0, 1);
    repeat (8) step(0, 0, 1);
    step(2, 0, 1);
    check("retrip_cnt", trip_cnt, 2);
    wait_reenable(n);
    check("retrip_reenable", n, CD + 1);

    // Overflow: six changes with the host stalled, then push+pop while full.
    step(3, 1, 1);
    step(0, 1, 1);
    repeat (4) step(0, 0, 1);
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 1 : 0, 0, 0);
    check("overflow_set", evt_overflow, 1);
    step(2, 0, 1);
    n = 0;
    while (evt_valid === 1'b1 && n < 20) begin
      step(2, 0, 1);
      n++;
    end
    check("full_pushpop_count", n, LD);
    check("overflow_sticky", evt_overflow, 1);

    // Randomized traffic with one asynchronous reset in the middle.
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        s = $urandom_range(0, 5);
        if (s > 3) s = 0;
      end
      step(s, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      if (i == 1500) begin
        #2 reset = 1'b1;
        #1;
        check("async_rst_gate_en", gate_en, 0);
        check("async_rst_evt_valid", evt_valid, 0);
        check("async_rst_trip_cnt", trip_cnt, 0);
        check("async_rst_alarm", alarm, 0);
        check("async_rst_overflow", evt_overflow, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("held_rst_gate_en", gate_en, 0);
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
